// File: rtl/normalizer32.sv
// Multi-cycle normalizer: binary search for the leading (left) or trailing (right)
// zero run. One stage per cycle, fixed SHW-cycle latency, valid/ready on both sides.
module normalizer32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shift_amount,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int TOP_STAGE_I = SHW - 1;
  localparam logic [SHW-1:0] TOP_STAGE = TOP_STAGE_I[SHW-1:0];
  localparam logic [SHW-1:0] ONE_SHW   = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] work_r;
  logic [SHW-1:0]   count_r;
  logic [SHW-1:0]   stage_r;
  logic             dir_r;
  logic             zero_in_r;

  logic [SHW-1:0]   step_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] work_next_s;
  logic [SHW-1:0]   count_next_s;

  // One binary-search stage: test the s-bit edge field and shift it out when clear.
  always_comb begin
    step_s       = ONE_SHW << stage_r;
    mask_s       = {WIDTH{1'b0}};
    work_next_s  = work_r;
    count_next_s = count_r;
    if (dir_r) begin
      mask_s = ~({WIDTH{1'b1}} << step_s);
    end else begin
      mask_s = ~({WIDTH{1'b1}} >> step_s);
    end
    if ((work_r & mask_s) == {WIDTH{1'b0}}) begin
      count_next_s = count_r + step_s;
      if (dir_r) begin
        work_next_s = work_r >> step_s;
      end else begin
        work_next_s = work_r << step_s;
      end
    end else begin
      work_next_s  = work_r;
      count_next_s = count_r;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      data_out     <= {WIDTH{1'b0}};
      shift_amount <= {SHW{1'b0}};
      zero         <= 1'b0;
      work_r       <= {WIDTH{1'b0}};
      count_r      <= {SHW{1'b0}};
      stage_r      <= {SHW{1'b0}};
      dir_r        <= 1'b0;
      zero_in_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_r    <= data_in;
            dir_r     <= direction;
            count_r   <= {SHW{1'b0}};
            stage_r   <= TOP_STAGE;
            zero_in_r <= (data_in == {WIDTH{1'b0}});
            zero      <= (data_in == {WIDTH{1'b0}});
            in_ready  <= 1'b0;
            state_r   <= SEARCH;
          end else begin
            state_r <= IDLE;
          end
        end
        SEARCH: begin
          work_r  <= work_next_s;
          count_r <= count_next_s;
          if (stage_r == {SHW{1'b0}}) begin
            data_out <= work_next_s;
            // An all-zero word would accumulate WIDTH-1; report zero shift instead.
            shift_amount <= zero_in_r ? {SHW{1'b0}} : count_next_s;
            out_valid    <= 1'b1;
            state_r      <= DONE;
          end else begin
            stage_r <= stage_r - ONE_SHW;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer32.sv
// Scoreboard bench for normalizer32: directed vectors plus random round-trip words.
module tb_normalizer32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        direction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [4:0]  shift_amount;
  logic        zero;

  typedef struct {
    logic [31:0] din;
    logic        dir;
    logic [31:0] dout;
    logic [4:0]  sh;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  normalizer32 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .direction(direction), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .shift_amount(shift_amount),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference counts by linear scan.
  function automatic logic [4:0] ref_clz(input logic [31:0] d);
    logic [4:0] n = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) return n;
      n = n + 5'd1;
    end
    return 5'd0;
  endfunction

  function automatic logic [4:0] ref_ctz(input logic [31:0] d);
    logic [4:0] n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) return n;
      n = n + 5'd1;
    end
    return 5'd0;
  endfunction

  // Monitor: compare every handed-off result with the scoreboard head.
  initial begin
    exp_t e;
    logic [31:0] back;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("data_out", data_out, e.dout);
          check("shift_amount", {27'd0, shift_amount}, {27'd0, e.sh});
          check("zero", {31'd0, zero}, {31'd0, e.z});
          back = e.dir ? (data_out << shift_amount) : (data_out >> shift_amount);
          check("round_trip", back, e.din);
        end
      end
    end
  end

  // Issue one request; optionally stall the consumer before handing off.
  task automatic do_req(input logic [31:0] d, input logic dir, input logic [31:0] exp_d,
                        input logic [4:0] exp_s, input logic exp_z, input int stall,
                        input logic noisy);
    exp_t e;
    int lat;
    logic [31:0] held_d;
    logic [4:0]  held_s;
    e.din = d; e.dir = dir; e.dout = exp_d; e.sh = exp_s; e.z = exp_z;
    sb_q.push_back(e);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    data_in   = d;
    direction = dir;
    @(posedge clk); #1;
    data_in   = $urandom;
    direction = ~dir;
    in_valid  = noisy;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("latency", lat, 32'd5);
    if (stall > 0) begin
      held_d = data_out;
      held_s = shift_amount;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_hold", {data_out[31:1], out_valid & ~in_ready & (held_s == shift_amount)},
              {held_d[31:1], 1'b1});
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("handoff", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        dir;
    reset = 1'b1; in_valid = 1'b0; data_in = 32'd0; direction = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outputs", {data_out[29:0], in_ready, out_valid},
          {30'd0, 1'b1, 1'b0});
    check("reset_shift_zero", {26'd0, shift_amount, zero}, 32'd0);

    do_req(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 0, 1'b1);
    do_req(32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 0, 1'b0);
    do_req(32'hF000_0000, 1'b0, 32'hF000_0000, 5'd0,  1'b0, 0, 1'b0);
    do_req(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, 0, 1'b0);
    do_req(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 0, 1'b0);
    do_req(32'h0001_2340, 1'b0, 32'h91A0_0000, 5'd15, 1'b0, 10, 1'b0);
    do_req(32'h0001_2340, 1'b1, 32'h0000_048D, 5'd6,  1'b0, 0, 1'b0);
    do_req(32'h0000_0001, 1'b1, 32'h0000_0001, 5'd0,  1'b0, 0, 1'b0);

    // Abort a request with reset two cycles after acceptance.
    in_valid = 1'b1; data_in = 32'h0000_0123; direction = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_state", {30'd0, in_ready, out_valid}, 32'd2);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    do_req(32'h0000_0100, 1'b1, 32'h0000_0001, 5'd8, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      dir = i[0];
      d = dir ? ($urandom << $urandom_range(0, 31)) : ($urandom >> $urandom_range(0, 31));
      if (d == 32'd0) d = 32'h0000_0400;
      if (dir) do_req(d, dir, d >> ref_ctz(d), ref_ctz(d), 1'b0, 0, 1'b0);
      else     do_req(d, dir, d << ref_clz(d), ref_clz(d), 1'b0, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
